if_fetch_unit: RTL and testbench

Instruction-fetch stage of the multi-cycle RV32I core, directly upstream of the instruction decoder. It owns the PC and the instruction register, runs a variable-latency request/valid handshake to instruction memory, and presents INSTR plus a one-cycle IRWrite strobe to the decoder. The control FSM starts each fetch with FETCH_EN and redirects the PC (jumps/branches) via PCWrite/PC_IN.

---
 rtl/if_fetch_unit_pkg.sv | 12 +
 rtl/if_fetch_unit_if.sv | 23 ++
 rtl/if_fetch_unit_timeout_ctr.sv | 24 ++
 rtl/if_fetch_unit.sv | 129 ++++++++++++
 tb/tb_if_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
package if_fetch_unit_pkg;
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;
endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port: request/valid handshake with a byte address.
interface if_fetch_unit_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              I_MEM_REQ;
    logic [ADDR_W-1:0] I_MEM_ADDR;
    logic [31:0]       I_MEM_DI;
    logic              I_MEM_VALID;

    modport master (
        output I_MEM_REQ,
        output I_MEM_ADDR,
        input  I_MEM_DI,
        input  I_MEM_VALID
    );

    modport slave (
        input  I_MEM_REQ,
        input  I_MEM_ADDR,
        output I_MEM_DI,
        output I_MEM_VALID
    );
endinterface

// File: rtl/if_fetch_unit_timeout_ctr.sv
// Wait-cycle counter for an outstanding fetch; flags expiry at TIMEOUT_CYC.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns PC and instruction register, fetches over a
// request/valid memory port and strobes IRWrite to the decoder.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FETCH_EN,
    input  logic                  PCWrite,
    input  logic [31:0]           PC_IN,
    if_fetch_unit_if.master       mem,
    output logic                  IRWrite,
    output logic [31:0]           INSTR,
    output logic [31:0]           PC,
    output logic [31:0]           PC_CUR,
    output logic                  FETCH_BUSY,
    output logic                  FETCH_ERR
);
    fetch_state_t state, state_nx;

    logic [31:0] pc_nx, instr_nx, pc_cur_nx, pend_pc, pend_pc_nx;
    logic        pend_flag, pend_flag_nx, err_nx;
    logic        ctr_clr, ctr_en, expired;

    fetch_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (CLK),
        .rst    (RST),
        .clr    (ctr_clr),
        .en     (ctr_en),
        .expired(expired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        pc_nx        = PC;
        instr_nx     = INSTR;
        pc_cur_nx    = PC_CUR;
        pend_pc_nx   = pend_pc;
        pend_flag_nx = pend_flag;
        err_nx       = 1'b0;
        ctr_clr      = 1'b0;
        ctr_en       = 1'b0;
        unique case (state)
            S_IDLE: begin
                ctr_clr = 1'b1;
                // A direct write in IDLE supersedes any target left over from an abandoned fetch.
                if (PCWrite) begin
                    pc_nx        = PC_IN;
                    pend_flag_nx = 1'b0;
                end
                if (FETCH_EN) begin
                    if (PC[1:0] == 2'b00) begin
                        state_nx = S_REQ;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            S_REQ, S_WAIT: begin
                if (PCWrite) begin
                    pend_pc_nx   = PC_IN;
                    pend_flag_nx = 1'b1;
                end
                if (mem.I_MEM_VALID) begin
                    instr_nx  = mem.I_MEM_DI;
                    pc_cur_nx = PC;
                    state_nx  = S_DONE;
                end else if (state == S_REQ) begin
                    ctr_en   = 1'b1;
                    state_nx = S_WAIT;
                end else if (expired) begin
                    err_nx   = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            S_DONE: begin
                if (PCWrite) begin
                    pc_nx = PC_IN;
                end else if (pend_flag) begin
                    pc_nx = pend_pc;
                end else begin
                    pc_nx = PC + PC_STEP;
                end
                pend_flag_nx = 1'b0;
                state_nx     = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            PC        <= RESET_PC;
            PC_CUR    <= RESET_PC;
            INSTR     <= NOP_INSTR;
            pend_pc   <= '0;
            pend_flag <= 1'b0;
            FETCH_ERR <= 1'b0;
        end else begin
            PC        <= pc_nx;
            PC_CUR    <= pc_cur_nx;
            INSTR     <= instr_nx;
            pend_pc   <= pend_pc_nx;
            pend_flag <= pend_flag_nx;
            FETCH_ERR <= err_nx;
        end
    end

    assign mem.I_MEM_REQ  = (state == S_REQ) || (state == S_WAIT);
    assign mem.I_MEM_ADDR = PC[ADDR_W-1:0];
    assign IRWrite        = (state == S_DONE);
    assign FETCH_BUSY     = (state != S_IDLE);
endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: expected fetches are queued as memory
// responds and retired on IRWrite.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        pc_write;
    logic [31:0] pc_in;
    logic        ir_write;
    logic [31:0] instr, pc, pc_cur;
    logic        fetch_busy, fetch_err;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc_cur;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   irw_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    if_fetch_unit_if #(.ADDR_W(12)) mem_if ();

    if_fetch_unit #(
        .ADDR_W     (12),
        .RESET_PC   (32'h0000_0000),
        .TIMEOUT_CYC(15)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .FETCH_EN  (fetch_en),
        .PCWrite   (pc_write),
        .PC_IN     (pc_in),
        .mem       (mem_if),
        .IRWrite   (ir_write),
        .INSTR     (instr),
        .PC        (pc),
        .PC_CUR    (pc_cur),
        .FETCH_BUSY(fetch_busy),
        .FETCH_ERR (fetch_err)
    );

    always @(negedge clk) begin
        if (ir_write === 1'b1) irw_cnt++;
        if (fetch_err === 1'b1) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one fetch; memory answers after `delay` wait cycles; optional PCWrite at loop step pw_at.
    task automatic fetch_once(input logic [31:0] data, input int unsigned delay,
                              input int pw_at, input logic [31:0] pw_val,
                              output int unsigned req_cycles, output logic addr_ok);
        logic [11:0] addr0;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        addr0 = mem_if.I_MEM_ADDR;
        req_cycles = 0;
        addr_ok = 1'b1;
        for (int i = 0; i <= int'(delay); i++) begin
            if (mem_if.I_MEM_REQ === 1'b1) req_cycles++;
            if (mem_if.I_MEM_ADDR !== addr0) addr_ok = 1'b0;
            mem_if.I_MEM_VALID = (i == int'(delay));
            mem_if.I_MEM_DI    = (i == int'(delay)) ? data : 32'hDEAD_BEEF;
            pc_write = (i == pw_at);
            pc_in    = pw_val;
            if (i == int'(delay)) sb.push_back('{data, pc});
            tick();
        end
        mem_if.I_MEM_VALID = 1'b0;
        pc_write = 1'b0;
    endtask

    task automatic retire(input string name);
        exp_t e;
        checks++;
        if (ir_write !== 1'b1) begin
            errors++;
            $display("FAIL %s_irwrite got %b want 1", name, ir_write);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_sb_empty got 0 entries want 1", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (instr !== e.instr || pc_cur !== e.pc_cur) begin
                errors++;
                $display("FAIL %s_instr got %h@%h want %h@%h", name, instr, pc_cur, e.instr, e.pc_cur);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (pc !== 32'h0 || pc_cur !== 32'h0 || instr !== 32'h0000_0013) begin
            errors++;
            $display("FAIL reset_regs got pc=%h pc_cur=%h instr=%h want 0/0/00000013", pc, pc_cur, instr);
        end
        checks++;
        if ({ir_write, mem_if.I_MEM_REQ, fetch_err, fetch_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000", {ir_write, mem_if.I_MEM_REQ, fetch_err, fetch_busy});
        end
    endtask

    task automatic test_zero_wait();
        int unsigned rc;
        logic aok;
        fetch_once(32'h00A0_0093, 0, -1, 32'h0, rc, aok);
        checks++;
        if (rc != 1 || aok !== 1'b1) begin
            errors++;
            $display("FAIL zw_req got cycles=%0d stable=%b want 1/1", rc, aok);
        end
        retire("zw");
        tick();
        checks++;
        if (pc !== 32'h4 || ir_write !== 1'b0) begin
            errors++;
            $display("FAIL zw_pc got pc=%h irw=%b want 00000004/0", pc, ir_write);
        end
    endtask

    task automatic test_delayed();
        int unsigned rc;
        logic aok;
        int irw0;
        irw0 = irw_cnt;
        fetch_once(32'h0010_0113, 3, -1, 32'h0, rc, aok);
        checks++;
        if (rc != 4 || aok !== 1'b1) begin
            errors++;
            $display("FAIL dly_req got cycles=%0d stable=%b want 4/1", rc, aok);
        end
        retire("dly");
        tick();
        checks++;
        if (pc !== 32'h8 || irw_cnt - irw0 != 1) begin
            errors++;
            $display("FAIL dly_pc got pc=%h strobes=%0d want 00000008/1", pc, irw_cnt - irw0);
        end
    endtask

    task automatic test_redirect();
        int unsigned rc;
        logic aok;
        fetch_once(32'h0020_0193, 2, 1, 32'h0000_0100, rc, aok);
        checks++;
        if (rc != 3 || aok !== 1'b1 || pc !== 32'h8) begin
            errors++;
            $display("FAIL rdw_hold got cycles=%0d stable=%b pc=%h want 3/1/00000008", rc, aok, pc);
        end
        retire("rdw");
        tick();
        checks++;
        if (pc !== 32'h100) begin
            errors++;
            $display("FAIL rdw_pc got %h want 00000100", pc);
        end
        fetch_once(32'h0030_0213, 0, -1, 32'h0, rc, aok);
        retire("rdd");
        pc_write = 1'b1;
        pc_in    = 32'h0000_0200;
        tick();
        pc_write = 1'b0;
        checks++;
        if (pc !== 32'h200) begin
            errors++;
            $display("FAIL rdd_pc got %h want 00000200", pc);
        end
    endtask

    task automatic test_timeout();
        int unsigned rc = 0;
        int irw0, err0;
        irw0 = irw_cnt;
        err0 = err_cnt;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_if.I_MEM_REQ === 1'b1) rc++;
            tick();
        end
        checks++;
        if (rc != 16 || err_cnt - err0 != 1) begin
            errors++;
            $display("FAIL to_req got cycles=%0d errs=%0d want 16/1", rc, err_cnt - err0);
        end
        checks++;
        if (irw_cnt != irw0 || instr !== 32'h0030_0213 || pc !== 32'h200 || fetch_busy !== 1'b0) begin
            errors++;
            $display("FAIL to_state got strobes=%0d instr=%h pc=%h busy=%b want 0/00300213/00000200/0",
                     irw_cnt - irw0, instr, pc, fetch_busy);
        end
    endtask

    task automatic test_misaligned();
        int unsigned rc = 0;
        int err0;
        pc_write = 1'b1;
        pc_in    = 32'h0000_0102;
        tick();
        pc_write = 1'b0;
        err0 = err_cnt;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        checks++;
        if (fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL mis_err got %b want 1", fetch_err);
        end
        for (int i = 0; i < 4; i++) begin
            if (mem_if.I_MEM_REQ === 1'b1) rc++;
            tick();
        end
        checks++;
        if (rc != 0 || err_cnt - err0 != 1 || pc !== 32'h102) begin
            errors++;
            $display("FAIL mis_req got req=%0d errs=%0d pc=%h want 0/1/00000102", rc, err_cnt - err0, pc);
        end
    endtask

    task automatic test_wrap();
        int unsigned rc;
        logic aok;
        pc_write = 1'b1;
        pc_in    = 32'hFFFF_FFFC;
        tick();
        pc_write = 1'b0;
        fetch_once(32'h0040_0293, 0, -1, 32'h0, rc, aok);
        checks++;
        if (mem_if.I_MEM_ADDR !== 12'hFFC) begin
            errors++;
            $display("FAIL wrap_addr got %h want ffc", mem_if.I_MEM_ADDR);
        end
        retire("wrap");
        tick();
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc got %h want 00000000", pc);
        end
    endtask

    task automatic test_reset_mid();
        int irw0;
        pc_write = 1'b1;
        pc_in    = 32'h0000_0300;
        tick();
        pc_write = 1'b0;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        tick();
        irw0 = irw_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_if.I_MEM_VALID = 1'b1;
        mem_if.I_MEM_DI    = 32'h0050_0313;
        tick();
        mem_if.I_MEM_VALID = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h0 || instr !== 32'h0000_0013 || fetch_busy !== 1'b0 || irw_cnt != irw0) begin
            errors++;
            $display("FAIL rstmid got pc=%h instr=%h busy=%b strobes=%0d want 0/00000013/0/0",
                     pc, instr, fetch_busy, irw_cnt - irw0);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d want 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        fetch_en = 1'b0;
        pc_write = 1'b0;
        pc_in = '0;
        mem_if.I_MEM_VALID = 1'b0;
        mem_if.I_MEM_DI = '0;
        test_reset();
        test_zero_wait();
        test_delayed();
        test_redirect();
        test_timeout();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
